// File: rtl/dram_ctrl_pkg.sv
// Shared types and helpers for the data-memory controller: FSM states, op encoding,
// default geometry and the even-parity function used when DRAM_PARITY_EN is defined.
package dram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int PAR_MAX_W      = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dram_ctrl_array.sv
// Single-port synchronous word RAM with registered read; contents are never reset.
module dram_array #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dram_ctrl.sv
// Data-memory controller: latches one load/store, inserts WAIT_STATES cycles, then performs it.
// Optional macro DRAM_PARITY_EN adds a stored even-parity bit and the parity_err check on loads.
//
// Handshake: a request (read_en|write_en) is taken only on an edge where busy is low; busy stays
// high until the access edge, and done pulses for the single cycle after it. Requests seen while
// busy are dropped, so a master holds its request until it observes done.
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [15:0]           addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  input  logic                  write_en,
  output logic [DATA_WIDTH-1:0] dram_out,
  output logic                  busy,
  output logic                  done,
  output logic                  parity_err
);

`ifdef DRAM_PARITY_EN
  localparam int RAM_W = DATA_WIDTH + 1;
`else
  localparam int RAM_W = DATA_WIDTH;
`endif

  state_t                state;
  op_t                   op_q;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [RAM_W-1:0]      ram_wdata;
  logic [RAM_W-1:0]      ram_rdata;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^addr_in[15:ADDR_WIDTH];

  // In IDLE the RAM sees the live address so a zero-wait load has its word ready at ACCESS.
  assign ram_addr = (state == S_IDLE) ? addr_in[ADDR_WIDTH-1:0] : addr_q;
  assign ram_we   = (state == S_ACCESS) && (op_q == OP_WR);

`ifdef DRAM_PARITY_EN
  assign ram_wdata = {even_parity(PAR_MAX_W'(data_q)), data_q};
`else
  assign ram_wdata = data_q;
  assign parity_err = 1'b0;
`endif

  dram_array #(
    .WIDTH      (RAM_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      op_q     <= OP_RD;
      cnt      <= 4'd0;
      addr_q   <= '0;
      data_q   <= '0;
      dram_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef DRAM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (read_en || write_en) begin
            addr_q <= addr_in[ADDR_WIDTH-1:0];
            data_q <= data_in;
            op_q   <= write_en ? OP_WR : OP_RD;
            cnt    <= 4'(WAIT_STATES);
            busy   <= 1'b1;
            state  <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
`ifdef DRAM_PARITY_EN
            parity_err <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= S_ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (op_q == OP_RD) begin
            dram_out <= ram_rdata[DATA_WIDTH-1:0];
`ifdef DRAM_PARITY_EN
            parity_err <= even_parity(PAR_MAX_W'(ram_rdata[DATA_WIDTH-1:0])) != ram_rdata[DATA_WIDTH];
`endif
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: directed corner cases plus randomized loads/stores, scored against
// a word-array model of memory; a second zero-wait-state instance covers the WAIT_STATES=0 path.
module tb_dram_ctrl;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int WS = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          read_en = 1'b0;
  logic          write_en = 1'b0;
  logic [DW-1:0] dram_out;
  logic          busy, done, parity_err;

  logic [15:0]   a0 = '0;
  logic [DW-1:0] d0 = '0;
  logic          rd0 = 1'b0;
  logic          wr0 = 1'b0;
  logic [DW-1:0] q0;
  logic          busy0, done0, perr0;

  always #5 clock = ~clock;

  dram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(WS)) u_dut (
    .clock(clock), .reset_n(reset_n), .addr_in(addr_in), .data_in(data_in),
    .read_en(read_en), .write_en(write_en), .dram_out(dram_out), .busy(busy),
    .done(done), .parity_err(parity_err)
  );

  dram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .addr_in(a0), .data_in(d0),
    .read_en(rd0), .write_en(wr0), .dram_out(q0), .busy(busy0),
    .done(done0), .parity_err(perr0)
  );

  int checks = 0;
  int errors = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] model_mem [2**AW];
  bit            written [2**AW];
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: stores update the word, loads update the visible output; each access
  // yields the {parity_err, dram_out} pair expected when its done pulse appears.
  task automatic model_push(input bit rd, input bit wr, input logic [15:0] a,
                            input logic [DW-1:0] d, input bit perr);
    int idx;
    idx = int'(a[AW-1:0]);
    if (wr) begin
      model_mem[idx] = d;
      written[idx] = 1'b1;
    end else if (rd) begin
      last_rd = model_mem[idx];
    end
    exp_q.push_back({perr, last_rd});
  endtask

  task automatic wait_done(input string name);
    int lat;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (done) begin
        lat = k;
        break;
      end
      chk({name, "_busy_in_flight"}, busy, 1);
    end
    chk({name, "_latency"}, lat, WS + 1);
    chk({name, "_busy_at_done"}, busy, 0);
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [DW-1:0] d, input bit perr);
    read_en = rd; write_en = wr; addr_in = a; data_in = d;
    model_push(rd, wr, a, d, perr);
    @(posedge clock); #1;
    read_en = 1'b0; write_en = 1'b0;
    addr_in = 16'($urandom); data_in = DW'($urandom);
    chk("busy_after_accept", busy, 1);
    wait_done("req");
  endtask

  always @(negedge clock) begin : monitor
    logic [DW:0] e;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no access pending");
      end else begin
        e = exp_q.pop_front();
        chk("dram_out", dram_out, e[DW-1:0]);
        chk("parity_err", parity_err, e[DW]);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dram_out", dram_out, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_dram_out0", q0, 0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Store then load with two wait states.
    do_req(0, 1, 16'h0003, 16'hA5A5, 0);
    do_req(1, 0, 16'h0003, '0, 0);

    // Both enables: store wins, output untouched.
    do_req(1, 1, 16'h0007, 16'h1234, 0);
    do_req(1, 0, 16'h0007, '0, 0);

    // Request changed and held while busy is ignored; held through done it is taken with no gap.
    write_en = 1'b1; addr_in = 16'h0020; data_in = 16'h5555;
    model_push(0, 1, 16'h0020, 16'h5555, 0);
    @(posedge clock); #1;
    addr_in = 16'h0021; data_in = 16'h6666;
    chk("b2b_busy_first", busy, 1);
    model_push(0, 1, 16'h0021, 16'h6666, 0);
    wait_done("b2b_first");
    @(posedge clock); #1;
    chk("b2b_no_gap", busy, 1);
    write_en = 1'b0;
    wait_done("b2b_second");
    do_req(1, 0, 16'h0020, '0, 0);
    do_req(1, 0, 16'h0021, '0, 0);

    // Upper address bits ignored.
    do_req(1, 0, 16'hFF07, '0, 0);

    // Zero-wait instance: done the cycle after accept, aliased address.
    wr0 = 1'b1; a0 = 16'hFF07; d0 = 16'h3C3C;
    @(posedge clock); #1;
    wr0 = 1'b0; a0 = 16'($urandom); d0 = DW'($urandom);
    chk("ws0_busy_accept", busy0, 1);
    chk("ws0_done_early", done0, 0);
    @(posedge clock); #1;
    chk("ws0_done_store", done0, 1);
    chk("ws0_busy_done", busy0, 0);
    rd0 = 1'b1; a0 = 16'h0007;
    @(posedge clock); #1;
    rd0 = 1'b0;
    @(posedge clock); #1;
    chk("ws0_done_load", done0, 1);
    chk("ws0_load_data", q0, 16'h3C3C);

    // Reset during the wait phase of a store: aborted, no done, word keeps its old value.
    do_req(0, 1, 16'h0010, 16'h1111, 0);
    write_en = 1'b1; addr_in = 16'h0010; data_in = 16'hBEEF;
    @(posedge clock); #1;
    write_en = 1'b0;
    chk("rst_mid_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_dram_out", dram_out, 0);
    last_rd = '0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    do_req(1, 0, 16'h0010, '0, 0);

    // Random traffic over a small window, upper address bits randomized.
    for (int i = 0; i < 80; i++) begin
      int r;
      logic [15:0] a;
      r = $urandom_range(0, 3);
      a = {8'($urandom), 8'($urandom_range(0, 31))};
      if (r == 0 && written[int'(a[AW-1:0])]) do_req(1, 0, a, DW'($urandom), 0);
      else if (r == 3) do_req(1, 1, a, DW'($urandom), 0);
      else do_req(0, 1, a, DW'($urandom), 0);
    end

`ifdef DRAM_PARITY_EN
    do_req(0, 1, 16'h0030, 16'h0001, 0);
    u_dut.u_array.mem[8'h30][DW] = ~u_dut.u_array.mem[8'h30][DW];
    do_req(1, 0, 16'h0030, '0, 1);
    do_req(1, 0, 16'h0003, '0, 0);
`endif

    repeat (4) @(posedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
